seq_comparator: RTL
===================

# seq_comparator

Parametrised multi-cycle magnitude comparator. It is the successor to the 4-bit combinational comparator. It accepts two N-bit operands on a start pulse and compares them chunk by chunk, MSB-first. It terminates early on the first differing chunk and reports registered L/E/G flags with a one-cycle done strobe. It supports unsigned and two's-complement modes, and it sits in datapaths whose operands are too wide for a single-cycle compare at the target clock.

## Interface
- N, 16, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; NCH = N/CHUNK chunks, NCH ≥ 1.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset; one clock, reset asynchronous and active-high.
- start  input  1  request; accepted only on an edge where busy=0.
- signed_mode  input  1  0 = unsigned compare, 1 = two's-complement; captured with operands.
- A  input  N  operand A; captured on accepting edge.
- B  input  N  operand B; captured on accepting edge.
- busy  output  1  compare in progress.
- done  output  1  one-cycle strobe: L/E/G updated this cycle.
- L  output  1  A < B (registered, held until next result).
- E  output  1  A == B (registered, held).
- G  output  1  A > B (registered, held).

## Operation
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1; chunk index k counts 0..NCH-1 from the MSB.
- IDLE → RUN: start=1 at an edge. A, B and signed_mode are latched, and k=0.
- In RUN, the following applies each cycle:
  - Chunk k of A is compared with chunk k of B, unsigned.
  - When signed_mode=1 and k=0, the MSB of both chunks is inverted before the compare (sign-bias).
  - Chunks differ: L/E/G are registered per the chunk result, done=1, FSM → IDLE.
  - Chunks equal and k=NCH-1: E=1, L=G=0, done=1, FSM → IDLE.
  - Otherwise k increments.
- Exactly one of L/E/G is 1 after the first result. All three are 0 from reset until the first done.
- start while busy=1 is ignored. There is no queueing, and the latched operands are unaffected.
- Input changes on A/B/signed_mode during RUN have no effect.
- Reset mid-operation: immediate return to IDLE, with all outputs cleared. No done is produced for the aborted compare.
- The k counter is $clog2(NCH) bits wide, minimum 1. It never wraps: RUN always exits at k=NCH-1.

## Timing
- Reset values:
  - busy=0, done=0, L=0, E=0, G=0.
  - FSM=IDLE, k=0.
- Start accepted at edge t0 sets busy=1 after t0.
- Let j be the index of the first differing chunk from the MSB. done=1 and the new L/E/G appear after edge t0+j+1.
- Latency is j+1 cycles. Equal operands take NCH cycles, the worst case. NCH=1 always gives 1 cycle.
- busy falls on the same edge that done rises. done lasts exactly one cycle.
- Back-to-back operation: start asserted during the done cycle is accepted, since busy=0. This gives a throughput of one compare per (latency+1) cycles.
- L/E/G are glitch-free registers and are stable between done strobes.

## Structure
- Shared package cmp_pkg holds:
  - the FSM state encoding (IDLE, RUN);
  - the result encoding constants (LT, EQ, GT) used for the internal 2-bit result;
  - a function computing NCH and the counter width.
- One sub-module, cmp_chunk: a combinational CHUNK-bit compare with a sign_bias input. It outputs lt/eq/gt and is instantiated once. seq_comparator muxes chunk k into it.
- seq_comparator contains the FSM, the operand registers, the chunk counter and the output registers.

## Test plan
Scenarios 1–5 use N=16 and CHUNK=4. Scenario 6 also runs at N=16/CHUNK=16 and N=32/CHUNK=8.

1. Assert rst for 3 cycles, then release with start low → busy=done=L=E=G=0. Then pulse rst during RUN → busy=0 and outputs cleared next cycle, with no done.
2. A=0x1234, B=0x1234, unsigned, start → done 4 cycles after the accepting edge, E=1, L=G=0.
3. A=0x9000, B=0x1000:
   - unsigned → done after 1 cycle, G=1;
   - signed → done after 1 cycle, L=1.
4. A=0x0005, B=0x0003, unsigned → done after 4 cycles, G=1. A=0x00A0, B=0x00B0 → done after 3 cycles, L=1.
5. Start A=0xFFFF, B=0x0000 (unsigned), then hold start high with A=0x0000, B=0xFFFF during busy → first result G=1 and the second start is ignored. The start held high during the done cycle is accepted, and the next result is L=1.
6. Sweep 17 iterations: A increments from 0 and B decrements from 0, in both modes → each result matches a behavioural <, ==, > reference. Latency must equal j+1.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared FSM/result encodings and sizing helpers for the sequential comparator
package cmp_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam logic [1:0] EQ = 2'b00;
    localparam logic [1:0] LT = 2'b01;
    localparam logic [1:0] GT = 2'b10;
    function automatic int nch_of(input int n, input int chunk);
        return n / chunk;
    endfunction
    function automatic int cnt_width(input int n, input int chunk);
        return (n / chunk) > 1 ? $clog2(n / chunk) : 1;
    endfunction
endpackage

// File: rtl/cmp_chunk.sv
// cmp_chunk: combinational CHUNK-bit unsigned compare with optional MSB sign-bias
module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             sign_bias,
    output logic             lt,
    output logic             eq,
    output logic             gt
);
    logic [CHUNK-1:0] bias, ab, bb;
    // flipping the top chunk's MSB turns a two's-complement compare into an unsigned one
    always_comb begin
        bias = CHUNK'(sign_bias) << (CHUNK - 1);
        ab   = a ^ bias;
        bb   = b ^ bias;
        lt   = ab < bb;
        eq   = ab == bb;
        gt   = ab > bb;
    end
endmodule

// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle MSB-first chunked magnitude comparator with early exit
module seq_comparator
    import cmp_pkg::*;
#(
    parameter int N     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         L,
    output logic         E,
    output logic         G
);
    localparam int NCH = nch_of(N, CHUNK);
    localparam int KW  = cnt_width(N, CHUNK);
    state_t state, next_state;
    logic [KW-1:0] k;
    logic [N-1:0] a_q, b_q;
    logic sm_q, lt, eq, gt, last, finish;
    logic [1:0] res;
    logic [CHUNK-1:0] ca [NCH];
    logic [CHUNK-1:0] cb [NCH];
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ca[i] = a_q[N-1-i*CHUNK -: CHUNK];
        assign cb[i] = b_q[N-1-i*CHUNK -: CHUNK];
    end
    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (ca[k]),
        .b        (cb[k]),
        .sign_bias(sm_q && k == '0),
        .lt       (lt),
        .eq       (eq),
        .gt       (gt)
    );
    // chunk result and termination condition for the current cycle
    always_comb begin
        last   = k == KW'(NCH - 1);
        finish = !eq || last;
        res    = lt ? LT : gt ? GT : EQ;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end
    // next-state logic
    always_comb begin
        next_state = state;
        if (state == IDLE) next_state = start ? RUN : IDLE;
        else               next_state = finish ? IDLE : RUN;
    end
    // state-derived outputs
    always_comb begin
        busy = state == RUN;
    end
    // operand capture, chunk counter and registered result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            sm_q <= 1'b0;
            k    <= '0;
            done <= 1'b0;
            L    <= 1'b0;
            E    <= 1'b0;
            G    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                a_q  <= A;
                b_q  <= B;
                sm_q <= signed_mode;
                k    <= '0;
            end else if (state == RUN) begin
                if (finish) begin
                    done <= 1'b1;
                    L    <= res == LT;
                    E    <= res == EQ;
                    G    <= res == GT;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end
endmodule
